clk_div_sequencer: RTL and testbench

Run-time programmable clock divider controller. It produces a 50 % duty divided clock `clk_div` and single-cycle edge ticks from `clk`, with a programmable half-period. Divide ratio changes and start/stop requests take effect only on full-period boundaries, so no runt pulse is ever generated. It replaces the fixed divide-by-2 stage wherever the lab designs need a selectable slow clock or enable.

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/half_period_counter.sv | 29 ++
 rtl/clk_div_sequencer.sv | 131 +++++++++++++
 tb/tb_clk_div_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the programmable clock divider.
package clk_div_pkg;

    localparam int DIV_CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } div_state_t;

endpackage

// File: rtl/half_period_counter.sv
// Counts 0..half-1 and flags the last cycle of each half-period.
module half_period_counter
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DIV_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             asyn_n_rst,
    input  logic             clear,
    input  logic [CNT_W-1:0] half,
    output logic             term
);

    logic [CNT_W-1:0] count;

    assign term = (count == (half - 1'b1));

    // Free-running half-period count, wraps on terminal count, held at 0 by clear.
    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            count <= '0;
        end else if (clear || term) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/clk_div_sequencer.sv
// Run-time programmable divider: FSM, pending half-period and registered outputs.
module clk_div_sequencer
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = DIV_CNT_W_DEF,
    parameter int DEFAULT_HALF = 1
) (
    input  logic             clk,
    input  logic             asyn_n_rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             clk_div,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             running
);

    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEFAULT_HALF);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] active_h;
    logic [CNT_W-1:0] pend_h;
    logic [CNT_W-1:0] cfg_clamped;
    logic             term;
    logic             xfer;
    logic             at_b;
    logic             clk_div_next;
    logic             active_load;
    logic [CNT_W-1:0] active_next;
    logic             pend_load;

    assign cfg_clamped = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
    assign xfer        = cfg_valid && cfg_ready;
    assign at_b        = (state != STOP) && !clk_div && term;

    half_period_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .asyn_n_rst (asyn_n_rst),
        .clear      (state == STOP),
        .half       (active_h),
        .term       (term)
    );

    // State register.
    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            state <= STOP;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start from STOP on en, stop or resume only at the end of a low phase.
    always_comb begin
        state_next = state;
        case (state)
            STOP: begin
                if (en) state_next = RUN;
            end
            RUN: begin
                if (at_b && !en) state_next = STOP;
                else if (xfer)   state_next = PEND;
            end
            PEND: begin
                if (at_b) state_next = en ? RUN : STOP;
            end
            default: state_next = STOP;
        endcase
    end

    // Outputs and datapath controls: handshake, next divided level, half-period updates.
    always_comb begin
        cfg_ready    = (state != PEND);
        running      = (state != STOP);
        clk_div_next = clk_div;
        active_load  = 1'b0;
        active_next  = active_h;
        pend_load    = 1'b0;
        case (state)
            STOP: begin
                clk_div_next = en;
                if (xfer) begin
                    active_load = 1'b1;
                    active_next = cfg_clamped;
                end
            end
            RUN: begin
                if (term) clk_div_next = clk_div ? 1'b0 : en;
                if (xfer) begin
                    if (at_b && !en) begin
                        active_load = 1'b1;
                        active_next = cfg_clamped;
                    end else begin
                        pend_load = 1'b1;
                    end
                end
            end
            PEND: begin
                if (term) clk_div_next = clk_div ? 1'b0 : en;
                if (at_b) begin
                    active_load = 1'b1;
                    active_next = pend_h;
                end
            end
            default: clk_div_next = 1'b0;
        endcase
    end

    // Registered divided clock, edge ticks, active and pending half-periods.
    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            clk_div   <= 1'b0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
            active_h  <= DEF_H;
            pend_h    <= DEF_H;
        end else begin
            clk_div   <= clk_div_next;
            tick_rise <= !clk_div && clk_div_next;
            tick_fall <= clk_div && !clk_div_next;
            if (active_load) active_h <= active_next;
            if (pend_load)   pend_h   <= cfg_clamped;
        end
    end

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Randomized and directed bench for clk_div_sequencer against a phase-level model.
module tb_clk_div_sequencer;

    localparam int DEF_HALF = 1;

    logic       clk;
    logic       asyn_n_rst;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_half;
    logic       cfg_ready;
    logic       clk_div;
    logic       tick_rise;
    logic       tick_fall;
    logic       running;

    int vectors     = 0;
    int miscompares = 0;

    // Model: phase level, cycles left in the phase, active H and a queue of pending H values.
    bit m_run;
    bit m_level;
    bit m_rise;
    bit m_fall;
    int m_left;
    int m_h;
    int pend_q[$];

    clk_div_sequencer #(
        .CNT_W        (8),
        .DEFAULT_HALF (DEF_HALF)
    ) dut (
        .clk        (clk),
        .asyn_n_rst (asyn_n_rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_half   (cfg_half),
        .cfg_ready  (cfg_ready),
        .clk_div    (clk_div),
        .tick_rise  (tick_rise),
        .tick_fall  (tick_fall),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] dut_vec();
        return {clk_div, tick_rise, tick_fall, running, cfg_ready};
    endfunction

    function automatic logic [4:0] model_vec();
        return {m_level, m_rise, m_fall, m_run, (pend_q.size() == 0)};
    endfunction

    task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b expected %b {clk_div,tick_rise,tick_fall,running,cfg_ready} at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_level = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_left  = 0;
        m_h     = DEF_HALF;
        pend_q.delete();
    endtask

    task automatic model_step(input bit e, input bit v, input int half);
        bit xfer;
        int ch;
        xfer   = v && (pend_q.size() == 0);
        ch     = (half == 0) ? 1 : half;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (!m_run) begin
            if (xfer) m_h = ch;
            if (e) begin
                m_run   = 1'b1;
                m_level = 1'b1;
                m_left  = m_h;
                m_rise  = 1'b1;
            end
        end else if (m_left > 1) begin
            m_left--;
            if (xfer) pend_q.push_back(ch);
        end else if (m_level) begin
            m_level = 1'b0;
            m_left  = m_h;
            m_fall  = 1'b1;
            if (xfer) pend_q.push_back(ch);
        end else begin
            if (pend_q.size() != 0) m_h = pend_q.pop_front();
            if (e) begin
                m_level = 1'b1;
                m_left  = m_h;
                m_rise  = 1'b1;
                if (xfer) pend_q.push_back(ch);
            end else begin
                m_run = 1'b0;
                if (xfer) m_h = ch;
            end
        end
    endtask

    task automatic applyStimulus(input logic rst_n_i, input logic e, input logic v,
                                 input logic [7:0] half, input string tag);
        @(negedge clk);
        asyn_n_rst = rst_n_i;
        en         = e;
        cfg_valid  = v;
        cfg_half   = half;
        if (!rst_n_i) model_reset();
        @(posedge clk);
        if (!rst_n_i) model_reset();
        else          model_step(e, v, int'(half));
        #1;
        checkOutput(tag, dut_vec(), model_vec());
    endtask

    // Reset asserted between edges, checked before the next clock edge.
    task automatic asyncResetPulse();
        #3;
        asyn_n_rst = 1'b0;
        #1;
        checkOutput("async_rst", dut_vec(), 5'b00001);
        model_reset();
    endtask

    initial begin
        bit en_r;
        asyn_n_rst = 1'b0;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        cfg_half   = '0;
        model_reset();

        // Reset held with en high: outputs idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            en = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("reset_hold", dut_vec(), 5'b00001);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, "release");

        // Default divide-by-2.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, "start");
        checkOutput("start_tick", {3'b000, clk_div, tick_rise}, 5'b00011);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, "div2");

        // Reconfigure to H=4 while running.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd4, "cfg4_xfer");
        checkOutput("cfg4_ready_low", {4'b0000, cfg_ready}, 5'b00000);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, "h4_run");

        // Drop en and let the period complete.
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, "h4_stop");
        checkOutput("stopped", {3'b000, clk_div, running}, 5'b00000);

        // Configure H=3 in STOP then start.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd3, "cfg3_stop");
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, "h3_run");

        // Zero half-period clamps to 1.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd0, "cfg0_xfer");
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, "h0_run");

        // Pending H=7 discarded by reset.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd7, "cfg7_xfer");
        checkOutput("cfg7_ready_low", {4'b0000, cfg_ready}, 5'b00000);
        asyncResetPulse();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, "rst_hold");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, "rst_release");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, "def_start");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, "def_fall");
        checkOutput("default_period", {4'b0000, clk_div}, 5'b00000);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, "def_run");

        // Random traffic with occasional en toggles, configs and resets.
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic rst_n_r;
            logic v_r;
            logic [7:0] h_r;
            if ($urandom_range(39, 0) == 0) en_r = ~en_r;
            rst_n_r = ($urandom_range(499, 0) != 0);
            v_r     = ($urandom_range(5, 0) == 0);
            h_r     = 8'($urandom_range(5, 0));
            applyStimulus(rst_n_r, en_r, v_r, h_r, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
